// File: rtl/alu_vec.sv
// 16-lane signed Q8.8 SIMD ALU with registered results and per-lane {N,Z,C,V} flags.
// Lane logic is purely combinational; one output register stage gives 1-cycle latency.
module alu_vec (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] a,
  input  logic [255:0] b,
  input  logic [2:0]   opcode,
  input  logic         flag_scalar,
  output logic [255:0] result,
  output logic [63:0]  flags
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  logic [255:0] result_d;
  logic [63:0]  flags_d;

  for (genvar i = 0; i < 16; i++) begin : g_lane
    logic [15:0]        lane_a;
    logic [15:0]        lane_b;
    logic [15:0]        lane_r;
    logic [16:0]        sum;
    logic signed [31:0] prod;
    logic signed [31:0] prod_sh;
    logic               lane_c;
    logic               lane_v;

    assign lane_a  = a[16*i +: 16];
    assign lane_b  = flag_scalar ? b[15:0] : b[16*i +: 16];
    assign sum     = {1'b0, lane_a} + {1'b0, lane_b};
    assign prod    = $signed(lane_a) * $signed(lane_b);
    // Dropping the 8 fraction bits realigns the Q16.16 product to Q8.8.
    assign prod_sh = prod >>> 8;

    always_comb begin
      lane_r = '0;
      lane_c = 1'b0;
      lane_v = 1'b0;
      case (opcode)
        OP_ADD: begin
          lane_r = sum[15:0];
          lane_c = sum[16];
          lane_v = (lane_a[15] == lane_b[15]) && (lane_r[15] != lane_a[15]);
        end
        OP_SUB: begin
          lane_r = lane_a - lane_b;
          lane_c = lane_a < lane_b;
          lane_v = (lane_a[15] != lane_b[15]) && (lane_r[15] != lane_a[15]);
        end
        OP_MUL: begin
          lane_r = prod_sh[15:0];
          lane_v = (prod_sh > 32'sd32767) || (prod_sh < -32'sd32768);
        end
        OP_AND: lane_r = lane_a & lane_b;
        OP_OR:  lane_r = lane_a | lane_b;
        OP_XOR: lane_r = lane_a ^ lane_b;
        OP_SLL: lane_r = lane_a << lane_b[3:0];
        OP_SRA: lane_r = $signed(lane_a) >>> lane_b[3:0];
      endcase
    end

    assign result_d[16*i +: 16] = lane_r;
    assign flags_d[4*i +: 4]    = {lane_r[15], (lane_r == 16'h0000), lane_c, lane_v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else begin
      result <= result_d;
      flags  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_vec.sv
// Bench for alu_vec: directed vector table, randomized back-to-back stream
// against an integer-arithmetic lane model, and asynchronous reset sequences.
module tb_alu_vec;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] a = '0;
  logic [255:0] b = '0;
  logic [2:0]   opcode = 3'b000;
  logic         flag_scalar = 1'b0;
  logic [255:0] result;
  logic [63:0]  flags;

  int checks = 0;
  int errors = 0;

  alu_vec dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .opcode(opcode),
    .flag_scalar(flag_scalar), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [255:0] va;
    logic [255:0] vb;
    logic [2:0]   op;
    logic         scal;
    logic [255:0] exp_r;
    logic [63:0]  exp_f;
  } vec_t;

  vec_t vecs[$];

  // Reference: each lane evaluated with plain integer arithmetic.
  function automatic void model(input logic [255:0] ma, input logic [255:0] mb,
                                input logic [2:0] op, input logic scal,
                                output logic [255:0] r, output logic [63:0] f);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] la, lb, r16;
      int ua, ub, sa, sb, t, res;
      bit c, v;
      la = ma[16*i +: 16];
      lb = scal ? mb[15:0] : mb[16*i +: 16];
      ua = int'(la);  ub = int'(lb);
      sa = int'($signed(la));  sb = int'($signed(lb));
      c = 0; v = 0; res = 0;
      case (op)
        3'd0: begin res = ua + ub; c = (res > 65535); t = sa + sb; v = (t > 32767) || (t < -32768); end
        3'd1: begin res = ua - ub; c = (ua < ub); t = sa - sb; v = (t > 32767) || (t < -32768); end
        3'd2: begin t = (sa * sb) >>> 8; res = t; v = (t > 32767) || (t < -32768); end
        3'd3: res = ua & ub;
        3'd4: res = ua | ub;
        3'd5: res = ua ^ ub;
        3'd6: res = ua << (ub % 16);
        default: res = sa >>> (ub % 16);
      endcase
      r16 = res[15:0];
      r[16*i +: 16] = r16;
      f[4*i +: 4] = {r16[15], (r16 == 16'h0), c, v};
    end
  endfunction

  task automatic chk(input string name, input logic [255:0] er, input logic [63:0] ef);
    checks++;
    if (result !== er) begin
      errors++;
      $display("FAIL %s result got %h want %h", name, result, er);
    end
    checks++;
    if (flags !== ef) begin
      errors++;
      $display("FAIL %s flags got %h want %h", name, flags, ef);
    end
  endtask

  function automatic vec_t lane0(input string n, input logic [15:0] a0, input logic [15:0] b0,
                                 input logic [2:0] op, input logic [15:0] r0, input logic [3:0] nib);
    vec_t t;
    t.name = n; t.va = {240'h0, a0}; t.vb = {240'h0, b0}; t.op = op; t.scal = 1'b0;
    t.exp_r = {240'h0, r0};
    t.exp_f = {60'h444444444444444, nib};
    return t;
  endfunction

  logic [255:0] mul_a, mul_b, er;
  logic [63:0]  ef;
  vec_t         tv;

  initial begin
    mul_a = 256'h0180_0140_0380_0180_0080_0300_0140_0000_0000_0000_0000_0000_0000_0000_0000_0140;
    mul_b = 256'hFE40_0180_0200_0340_05C0_FF80_FE80_0000_0000_0000_0000_0000_0000_0000_0000_FE80;
    tv = '{"mul_lane", mul_a, mul_b, 3'b010, 1'b0,
           256'hFD60_01E0_0700_04E0_02E0_FE80_FE20_0000_0000_0000_0000_0000_0000_0000_0000_FE20,
           64'h8000_0884_4444_4448};
    vecs.push_back(tv);
    tv = '{"mul_scalar", mul_a, mul_b, 3'b010, 1'b1,
           256'hFDC0_FE20_FAC0_FDC0_FF40_FB80_FE20_0000_0000_0000_0000_0000_0000_0000_0000_FE20,
           64'h8888_8884_4444_4448};
    vecs.push_back(tv);
    vecs.push_back(lane0("mul_ovf", 16'h7F00, 16'h0200, 3'b010, 16'hFE00, 4'h9));
    vecs.push_back(lane0("add_ovf", 16'h7FFF, 16'h0001, 3'b000, 16'h8000, 4'h9));
    vecs.push_back(lane0("add_carry", 16'hFFFF, 16'h0001, 3'b000, 16'h0000, 4'h6));
    vecs.push_back(lane0("sub_borrow", 16'h0000, 16'h0001, 3'b001, 16'hFFFF, 4'hA));
    vecs.push_back(lane0("and", 16'hF0F0, 16'h0FF0, 3'b011, 16'h00F0, 4'h0));
    vecs.push_back(lane0("sll", 16'h0001, 16'h0004, 3'b110, 16'h0010, 4'h0));
    vecs.push_back(lane0("sra", 16'h8000, 16'h000F, 3'b111, 16'hFFFF, 4'h8));

    #1 chk("reset_state", '0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      a = vecs[k].va; b = vecs[k].vb; opcode = vecs[k].op; flag_scalar = vecs[k].scal;
      @(posedge clk);
      #1 chk(vecs[k].name, vecs[k].exp_r, vecs[k].exp_f);
    end

    // Back-to-back random stream: each negedge checks the operation captured one edge earlier.
    @(negedge clk);
    a = {8{$urandom}}; b = {8{$urandom}}; opcode = 3'($urandom); flag_scalar = 1'($urandom);
    model(a, b, opcode, flag_scalar, er, ef);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      chk("random", er, ef);
      for (int w = 0; w < 8; w++) begin
        a[32*w +: 32] = $urandom;
        b[32*w +: 32] = (n % 4 == 0) ? ($urandom & 32'h000F000F) : $urandom;
      end
      opcode = 3'($urandom_range(0, 7));
      flag_scalar = 1'($urandom);
      model(a, b, opcode, flag_scalar, er, ef);
    end

    // Asynchronous reset between edges while outputs are nonzero.
    @(negedge clk);
    a = mul_a; b = mul_b; opcode = 3'b010; flag_scalar = 1'b1;
    model(a, b, opcode, flag_scalar, er, ef);
    @(posedge clk);
    #1 chk("pre_reset", er, ef);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", '0, '0);
    @(posedge clk);
    #1 chk("reset_hold", '0, '0);
    @(negedge clk);
    opcode = 3'b000; flag_scalar = 1'b0;
    model(a, b, opcode, flag_scalar, er, ef);
    rst_n = 1'b1;
    #1 chk("release_no_edge", '0, '0);
    @(posedge clk);
    #1 chk("release_first_edge", er, ef);

    // Opcode and scalar changes land only on the following edge.
    @(negedge clk);
    opcode = 3'b101; flag_scalar = 1'b1;
    #1 chk("no_early_change", er, ef);
    model(a, b, opcode, flag_scalar, er, ef);
    @(posedge clk);
    #1 chk("change_applied", er, ef);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
